// File: rtl/vram_pkg.sv
// Shared sizes and state encoding for the VRAM pending-to-current copy engine.
package vram_pkg;

    localparam int DATA_W      = 32;
    localparam int CNT_W       = 11;

    localparam int TILE_AW     = 11;
    localparam int TILE_DEPTH  = 2048;
    localparam int PAT_AW      = 10;
    localparam int PAT_DEPTH   = 1024;
    localparam int SPR_AW      = 6;
    localparam int SPR_DEPTH   = 64;
    localparam int PAL_AW      = 8;
    localparam int PAL_DEPTH   = 256;

    // Last counter value visited; the tile region is the deepest and sets it.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TILE_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COPY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/vram_if.sv
// Four-region VRAM port: the user side drives address/write data/enable,
// the memory side returns read data one cycle after the address.
interface vram_if;
    import vram_pkg::*;

    logic [TILE_AW-1:0] tileAddr;
    logic [DATA_W-1:0]  tileWrData;
    logic               tileWrEn;
    logic [DATA_W-1:0]  tileRdData;

    logic [PAT_AW-1:0]  patAddr;
    logic [DATA_W-1:0]  patWrData;
    logic               patWrEn;
    logic [DATA_W-1:0]  patRdData;

    logic [SPR_AW-1:0]  sprAddr;
    logic [DATA_W-1:0]  sprWrData;
    logic               sprWrEn;
    logic [DATA_W-1:0]  sprRdData;

    logic [PAL_AW-1:0]  palAddr;
    logic [DATA_W-1:0]  palWrData;
    logic               palWrEn;
    logic [DATA_W-1:0]  palRdData;

    modport usr (
        output tileAddr, tileWrData, tileWrEn,
        output patAddr,  patWrData,  patWrEn,
        output sprAddr,  sprWrData,  sprWrEn,
        output palAddr,  palWrData,  palWrEn,
        input  tileRdData, patRdData, sprRdData, palRdData
    );

    modport src (
        input  tileAddr, tileWrData, tileWrEn,
        input  patAddr,  patWrData,  patWrEn,
        input  sprAddr,  sprWrData,  sprWrEn,
        input  palAddr,  palWrData,  palWrEn,
        output tileRdData, patRdData, sprRdData, palRdData
    );

endinterface

// File: rtl/vram_copy_lane.sv
// One region's copy lane: truncates the shared counter into a read address,
// delays that address by the memory read latency, and only enables the write
// when the counter was still inside this region's depth.
module vram_copy_lane
    import vram_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 256
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              active_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic [DATA_W-1:0] rdData_i,
    output logic [AW-1:0]     rdAddr_o,
    output logic [AW-1:0]     wrAddr_o,
    output logic [DATA_W-1:0] wrData_o,
    output logic              wrEn_o
);

    // One extra bit so a full 2048-deep region compares correctly against an 11-bit count.
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    logic          inRange;
    logic [AW-1:0] wrAddr_q, wrAddr_d;
    logic          wrEn_q, wrEn_d;

    assign inRange  = ({1'b0, cnt_i} < DEPTH_L);
    assign rdAddr_o = active_i ? cnt_i[AW-1:0] : '0;

    // The write for the address read this cycle happens next cycle, when its data returns.
    always_comb begin
        wrAddr_d = rdAddr_o;
        wrEn_d   = active_i && inRange;
    end

    // Delay stage matching the one-cycle read latency; reset kills any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrAddr_q <= '0;
            wrEn_q   <= 1'b0;
        end else begin
            wrAddr_q <= wrAddr_d;
            wrEn_q   <= wrEn_d;
        end
    end

    assign wrAddr_o = wrAddr_q;
    assign wrEn_o   = wrEn_q;
    assign wrData_o = wrEn_q ? rdData_i : '0;

endmodule

// File: rtl/vram_sync_writer.sv
// Copies the pending VRAM into the current VRAM on a sync request, all four
// regions walked in parallel by one shared counter, and pulses done at the end.
module vram_sync_writer
    import vram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sync,
    output logic done,
    vram_if.usr  vram_ifP_usr,
    vram_if.usr  vram_ifC_usr
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             copyActive;
    logic             unusedCRdData;

    logic [TILE_AW-1:0] tileRdAddr, tileWrAddr;
    logic [PAT_AW-1:0]  patRdAddr,  patWrAddr;
    logic [SPR_AW-1:0]  sprRdAddr,  sprWrAddr;
    logic [PAL_AW-1:0]  palRdAddr,  palWrAddr;
    logic [DATA_W-1:0]  tileWrData, patWrData, sprWrData, palWrData;
    logic               tileWrEn,   patWrEn,   sprWrEn,   palWrEn;

    // Sequencer: wait for sync, walk the counter, one drain cycle for the last write, then done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync) begin
                    state_d = ST_COPY;
                    cnt_d   = '0;
                end
            end
            ST_COPY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and done registers; reset abandons any copy in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign copyActive = (state_q == ST_COPY);
    assign done       = done_q;

    vram_copy_lane #(.AW(TILE_AW), .DEPTH(TILE_DEPTH)) uTileLane (
        .clk      (clk),
        .rst      (rst),
        .active_i (copyActive),
        .cnt_i    (cnt_q),
        .rdData_i (vram_ifP_usr.tileRdData),
        .rdAddr_o (tileRdAddr),
        .wrAddr_o (tileWrAddr),
        .wrData_o (tileWrData),
        .wrEn_o   (tileWrEn)
    );

    vram_copy_lane #(.AW(PAT_AW), .DEPTH(PAT_DEPTH)) uPatLane (
        .clk      (clk),
        .rst      (rst),
        .active_i (copyActive),
        .cnt_i    (cnt_q),
        .rdData_i (vram_ifP_usr.patRdData),
        .rdAddr_o (patRdAddr),
        .wrAddr_o (patWrAddr),
        .wrData_o (patWrData),
        .wrEn_o   (patWrEn)
    );

    vram_copy_lane #(.AW(SPR_AW), .DEPTH(SPR_DEPTH)) uSprLane (
        .clk      (clk),
        .rst      (rst),
        .active_i (copyActive),
        .cnt_i    (cnt_q),
        .rdData_i (vram_ifP_usr.sprRdData),
        .rdAddr_o (sprRdAddr),
        .wrAddr_o (sprWrAddr),
        .wrData_o (sprWrData),
        .wrEn_o   (sprWrEn)
    );

    vram_copy_lane #(.AW(PAL_AW), .DEPTH(PAL_DEPTH)) uPalLane (
        .clk      (clk),
        .rst      (rst),
        .active_i (copyActive),
        .cnt_i    (cnt_q),
        .rdData_i (vram_ifP_usr.palRdData),
        .rdAddr_o (palRdAddr),
        .wrAddr_o (palWrAddr),
        .wrData_o (palWrData),
        .wrEn_o   (palWrEn)
    );

    // The pending VRAM is only ever read.
    assign vram_ifP_usr.tileAddr   = tileRdAddr;
    assign vram_ifP_usr.tileWrData = '0;
    assign vram_ifP_usr.tileWrEn   = 1'b0;
    assign vram_ifP_usr.patAddr    = patRdAddr;
    assign vram_ifP_usr.patWrData  = '0;
    assign vram_ifP_usr.patWrEn    = 1'b0;
    assign vram_ifP_usr.sprAddr    = sprRdAddr;
    assign vram_ifP_usr.sprWrData  = '0;
    assign vram_ifP_usr.sprWrEn    = 1'b0;
    assign vram_ifP_usr.palAddr    = palRdAddr;
    assign vram_ifP_usr.palWrData  = '0;
    assign vram_ifP_usr.palWrEn    = 1'b0;

    // The current VRAM is only ever written.
    assign vram_ifC_usr.tileAddr   = tileWrAddr;
    assign vram_ifC_usr.tileWrData = tileWrData;
    assign vram_ifC_usr.tileWrEn   = tileWrEn;
    assign vram_ifC_usr.patAddr    = patWrAddr;
    assign vram_ifC_usr.patWrData  = patWrData;
    assign vram_ifC_usr.patWrEn    = patWrEn;
    assign vram_ifC_usr.sprAddr    = sprWrAddr;
    assign vram_ifC_usr.sprWrData  = sprWrData;
    assign vram_ifC_usr.sprWrEn    = sprWrEn;
    assign vram_ifC_usr.palAddr    = palWrAddr;
    assign vram_ifC_usr.palWrData  = palWrData;
    assign vram_ifC_usr.palWrEn    = palWrEn;

    assign unusedCRdData = ^{vram_ifC_usr.tileRdData, vram_ifC_usr.patRdData,
                             vram_ifC_usr.sprRdData,  vram_ifC_usr.palRdData};

endmodule

// File: tb/tb_vram_sync_writer.sv
// Bench for vram_sync_writer: a two-VRAM memory model around the DUT,
// a short cycle-by-cycle vector table at copy start, then directed
// sequences for completion timing, ignored sync, reset abort and
// back-to-back copies.
module tb_vram_sync_writer;
    import vram_pkg::*;

    localparam logic [31:0] SENT = 32'hC0FF_EE00;

    typedef struct {
        logic        sync;
        logic [10:0] expTileRd;
        logic        expWrEn;
        logic [10:0] expWrAddr;
        logic        expDone;
    } vec_t;

    vec_t vecs[6];

    logic clk = 1'b0;
    logic rst;
    logic sync;
    logic done;
    logic [7:0] seed;
    logic cClear;

    int cyc = 0;
    int vecCount = 0;
    int missCount = 0;
    int doneCnt = 0;
    int doneAt[8];
    int tileWr = 0, patWr = 0, sprWr = 0, palWr = 0;
    int pWrenSeen = 0;
    int lastTileEdge = 0;
    int e0, e1, e2, e3;

    logic [31:0] cTile[2048];
    logic [31:0] cPat[1024];
    logic [31:0] cSpr[64];
    logic [31:0] cPal[256];

    vram_if ifP();
    vram_if ifC();

    vram_sync_writer dut (
        .clk          (clk),
        .rst          (rst),
        .sync         (sync),
        .done         (done),
        .vram_ifP_usr (ifP),
        .vram_ifC_usr (ifC)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Contents of the pending VRAM: region tag, seed and address packed into each word.
    function automatic logic [31:0] pData(input int region, input int addr, input logic [7:0] s);
        if (region == 2 && addr == 63) return 32'hDEAD_BEEF;
        return {4'(region), s, 20'(addr)};
    endfunction

    // Pending VRAM model with one-cycle read latency; also watches for any write attempt.
    always @(posedge clk) begin
        ifP.tileRdData <= pData(0, int'(ifP.tileAddr), seed);
        ifP.patRdData  <= pData(1, int'(ifP.patAddr),  seed);
        ifP.sprRdData  <= pData(2, int'(ifP.sprAddr),  seed);
        ifP.palRdData  <= pData(3, int'(ifP.palAddr),  seed);
        if (ifP.tileWrEn || ifP.patWrEn || ifP.sprWrEn || ifP.palWrEn)
            pWrenSeen <= pWrenSeen + 1;
    end

    // Current VRAM model: clearable to a sentinel, counts writes per region.
    always @(posedge clk) begin
        if (cClear) begin
            for (int i = 0; i < 2048; i++) cTile[i] <= SENT;
            for (int i = 0; i < 1024; i++) cPat[i]  <= SENT;
            for (int i = 0; i < 64;   i++) cSpr[i]  <= SENT;
            for (int i = 0; i < 256;  i++) cPal[i]  <= SENT;
            tileWr <= 0;
            patWr  <= 0;
            sprWr  <= 0;
            palWr  <= 0;
        end else begin
            if (ifC.tileWrEn) begin
                cTile[ifC.tileAddr] <= ifC.tileWrData;
                tileWr <= tileWr + 1;
                if (ifC.tileAddr == 11'd2047) lastTileEdge <= cyc + 1;
            end
            if (ifC.patWrEn) begin
                cPat[ifC.patAddr] <= ifC.patWrData;
                patWr <= patWr + 1;
            end
            if (ifC.sprWrEn) begin
                cSpr[ifC.sprAddr] <= ifC.sprWrData;
                sprWr <= sprWr + 1;
            end
            if (ifC.palWrEn) begin
                cPal[ifC.palAddr] <= ifC.palWrData;
                palWr <= palWr + 1;
            end
        end
        ifC.tileRdData <= cTile[ifC.tileAddr];
        ifC.patRdData  <= cPat[ifC.patAddr];
        ifC.sprRdData  <= cSpr[ifC.sprAddr];
        ifC.palRdData  <= cPal[ifC.palAddr];
    end

    // Edge counter and done-pulse recorder (records the index of the edge that raised done).
    always @(posedge clk) begin
        if (done) begin
            if (doneCnt < 8) doneAt[doneCnt] = cyc;
            doneCnt = doneCnt + 1;
        end
        cyc <= cyc + 1;
    end

    // Safety net against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s);
        sync = s;
        @(negedge clk);
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic clearC();
        cClear = 1'b1;
        @(negedge clk);
        cClear = 1'b0;
    endtask

    task automatic checkVector(input int k);
        checkOutput($sformatf("vec%0d P tile addr", k), 32'(ifP.tileAddr), 32'(vecs[k].expTileRd));
        checkOutput($sformatf("vec%0d C tile wren", k), 32'(ifC.tileWrEn), 32'(vecs[k].expWrEn));
        checkOutput($sformatf("vec%0d C tile addr", k), 32'(ifC.tileAddr), 32'(vecs[k].expWrAddr));
        checkOutput($sformatf("vec%0d done", k),        32'(done),         32'(vecs[k].expDone));
        if (vecs[k].expWrEn)
            checkOutput($sformatf("vec%0d C tile wrdata", k), ifC.tileWrData,
                        pData(0, int'(vecs[k].expWrAddr), seed));
    endtask

    // Counts words that differ from expectation: copied below upTo, sentinel from upTo on.
    task automatic checkRegion(input string name, input int region, input int depth,
                               input int upTo, input logic [7:0] s);
        int bad;
        logic [31:0] got, exp;
        bad = 0;
        for (int i = 0; i < depth; i++) begin
            case (region)
                0:       got = cTile[i];
                1:       got = cPat[i];
                2:       got = cSpr[i];
                default: got = cPal[i];
            endcase
            exp = (i < upTo) ? pData(region, i, s) : SENT;
            if (got !== exp) bad++;
        end
        checkOutput({name, " bad words"}, 32'(bad), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 11'd0, 1'b0, 11'd0, 1'b0};
        vecs[1] = '{1'b1, 11'd0, 1'b0, 11'd0, 1'b0};
        vecs[2] = '{1'b0, 11'd1, 1'b1, 11'd0, 1'b0};
        vecs[3] = '{1'b1, 11'd2, 1'b1, 11'd1, 1'b0};
        vecs[4] = '{1'b1, 11'd3, 1'b1, 11'd2, 1'b0};
        vecs[5] = '{1'b0, 11'd4, 1'b1, 11'd3, 1'b0};

        rst    = 1'b1;
        sync   = 1'b0;
        cClear = 1'b0;
        seed   = 8'h11;
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("reset done",          32'(done),           32'd0);
        checkOutput("reset C tile wren",   32'(ifC.tileWrEn),   32'd0);
        checkOutput("reset C spr wren",    32'(ifC.sprWrEn),    32'd0);
        checkOutput("reset C tile addr",   32'(ifC.tileAddr),   32'd0);
        checkOutput("reset C tile wrdata", ifC.tileWrData,      32'd0);
        checkOutput("reset P tile addr",   32'(ifP.tileAddr),   32'd0);
        clearC();
        rst = 1'b0;

        $display("[TB] copy 1: start vectors");
        e0 = cyc + 2;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(vecs[k].sync);
            checkVector(k);
        end

        $display("[TB] copy 1: sync re-pulsed mid-copy");
        waitUntil(e0 + 99);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        waitUntil(e0 + 2050);
        checkOutput("copy1 done count",      32'(doneCnt),      32'd1);
        checkOutput("copy1 done edge",       32'(doneAt[0]),    32'(e0 + 2049));
        checkOutput("copy1 last tile edge",  32'(lastTileEdge), 32'(e0 + 2049));
        checkOutput("copy1 tile writes",     32'(tileWr),       32'd2048);
        checkOutput("copy1 pattern writes",  32'(patWr),        32'd1024);
        checkOutput("copy1 sprite writes",   32'(sprWr),        32'd64);
        checkOutput("copy1 palette writes",  32'(palWr),        32'd256);
        checkOutput("copy1 sprite word 63",  cSpr[63],          32'hDEAD_BEEF);
        checkRegion("copy1 tile",    0, 2048, 2048, seed);
        checkRegion("copy1 pattern", 1, 1024, 1024, seed);
        checkRegion("copy1 sprite",  2, 64,   64,   seed);
        checkRegion("copy1 palette", 3, 256,  256,  seed);

        $display("[TB] copy 2: sync 2052 cycles after the first");
        seed = 8'h5B;
        clearC();
        e1 = e0 + 2052;
        waitUntil(e1 - 1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        waitUntil(e1 + 2050);
        checkOutput("copy2 done count", 32'(doneCnt),   32'd2);
        checkOutput("copy2 done edge",  32'(doneAt[1]), 32'(e1 + 2049));
        checkOutput("copy2 tile writes",   32'(tileWr), 32'd2048);
        checkOutput("copy2 sprite writes", 32'(sprWr),  32'd64);
        checkRegion("copy2 tile",    0, 2048, 2048, seed);
        checkRegion("copy2 pattern", 1, 1024, 1024, seed);
        checkRegion("copy2 sprite",  2, 64,   64,   seed);
        checkRegion("copy2 palette", 3, 256,  256,  seed);

        $display("[TB] copy 3: reset at cycle 1000");
        seed = 8'h3C;
        clearC();
        doneCnt = 0;
        e2 = cyc + 1;
        applyStimulus(1'b1);
        sync = 1'b0;
        waitUntil(e2 + 1000);
        rst = 1'b1;
        #1;
        checkOutput("abort C tile wren",   32'(ifC.tileWrEn), 32'd0);
        checkOutput("abort C pat wren",    32'(ifC.patWrEn),  32'd0);
        checkOutput("abort C tile addr",   32'(ifC.tileAddr), 32'd0);
        checkOutput("abort C tile wrdata", ifC.tileWrData,    32'd0);
        checkOutput("abort P tile addr",   32'(ifP.tileAddr), 32'd0);
        checkOutput("abort done",          32'(done),         32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        waitUntil(e2 + 2100);
        checkOutput("abort done count",    32'(doneCnt), 32'd0);
        checkOutput("abort tile writes",   32'(tileWr),  32'd999);
        checkOutput("abort pattern writes", 32'(patWr),  32'd999);
        checkOutput("abort sprite writes", 32'(sprWr),   32'd64);
        checkRegion("abort tile",    0, 2048, 999, seed);
        checkRegion("abort pattern", 1, 1024, 999, seed);

        $display("[TB] copy 4: sync held high for 5000 cycles");
        doneCnt = 0;
        e3 = cyc + 1;
        sync = 1'b1;
        waitUntil(e3 + 4999);
        sync = 1'b0;
        waitUntil(e3 + 6160);
        checkOutput("held done count",  32'(doneCnt),   32'd3);
        checkOutput("held done edge 1", 32'(doneAt[0]), 32'(e3 + 2049));
        checkOutput("held done edge 2", 32'(doneAt[1]), 32'(e3 + 4099));
        checkOutput("held done edge 3", 32'(doneAt[2]), 32'(e3 + 6149));
        checkOutput("P wren ever high", 32'(pWrenSeen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/vram_sync_writer.md
VRAM_SYNC_WRITER -- requirements
Module: vram_sync_writer

Interface
REQ-001 Parameters: none; all sizes SHALL come from package vram_pkg.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 sync  input  1  copy request, sampled on rising clk edge.
REQ-005 done  output  1  one-cycle pulse on copy completion.
REQ-006 vram_ifP_usr  vram_if.usr  -  source (pending) VRAM; read-only use.
REQ-007 vram_ifC_usr  vram_if.usr  -  destination (current) VRAM; write-only use.
REQ-008 vram_if SHALL carry four regions, each with usr-driven addr, wrdata[31:0], wren and src-driven rddata[31:0]; read latency is exactly 1 cycle.
REQ-009 Region depths: tile 2048 (addr 11b), pattern 1024 (10b), sprite 64 (6b), palette 256 (8b).

Function
REQ-010 The block SHALL copy every word of every region from P to C, all regions in parallel, driven by one 11-bit counter cnt.
REQ-011 States: IDLE, COPY, DRAIN.
REQ-012 IDLE: P and C wren all 0; P addrs 0; sync=1 at an edge -> COPY with cnt=0.
REQ-013 COPY: each region's P addr = cnt truncated to its width; at cnt=2047 -> DRAIN; otherwise cnt+1.
REQ-014 Write path: one cycle after P addr=a is driven, C addr=a, C wrdata=P rddata, C wren=1, but only if a < that region's depth.
REQ-015 Writes at or beyond a region's depth SHALL be suppressed (wren=0); no region wraps or is overwritten.
REQ-016 DRAIN: issues the final write (tile addr 2047) for one cycle, then -> IDLE with done=1 for exactly one cycle.
REQ-017 Latency: if sync is sampled at edge E0, tile word i is written at edge E(i+2); last write at E2049; done high during the cycle after E2049.
REQ-018 P wren SHALL be 0 at all times; C addrs SHALL not be read.
REQ-019 sync while COPY/DRAIN SHALL be ignored (not queued).
REQ-020 sync sampled in the cycle done is high SHALL start a new copy (state is already IDLE).
REQ-021 sync held high continuously SHALL produce back-to-back copies, 2050 cycles per copy.
REQ-022 done SHALL never be asserted outside the single completion cycle.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, cnt=0, done=0 and all wren=0, addrs=0, wrdata=0.
REQ-024 Reset mid-copy SHALL abort with no further writes and no done pulse; C keeps partial contents.
REQ-025 After rst deassertion the block SHALL wait for a new sync.

Structure
REQ-026 vram_pkg SHALL hold region depths, address widths, data width (32) and the state enum.
REQ-027 One sub-module, vram_copy_lane (parameterised by address width/depth), SHALL implement a region's truncated address, delayed write address and gated wren; instantiated four times.
REQ-028 vram_if is the shared interface with usr/src modports; vram_test is the bench memory model (two VRAMs, 1-cycle read, swap input tied 0).

Verification
REQ-029 Reset 1 cycle, sync pulse 1 cycle -> done one-cycle pulse 2049 cycles after sampling edge; C tile[0..2047] equals P tile; C pattern/sprite/palette equal P.
REQ-030 Second sync 2052 cycles after the first -> second copy completes identically; exactly two done pulses total.
REQ-031 sync re-pulsed at cycle 100 of a copy -> ignored; only one done, at the original time.
REQ-032 rst asserted at cycle 1000 of a copy -> wren drops immediately, no done; C tile[0..~997] updated, rest unchanged.
REQ-033 P sprite word 63 = 0xDEADBEEF, sprite depth 64 -> C sprite[63]=0xDEADBEEF; no C sprite write with cnt>=64.
REQ-034 sync held high 5000 cycles -> done pulses every 2050 cycles; P wren never 1.
